// File: rtl/fp16_div_pkg.sv
// rtl/fp16_div_pkg.sv - shared fp16 constants, iterative-unit FSM encodings and operand classification
//
// Purpose: constants shared by the fp16 arithmetic library (qNaN, zero, +inf, exponent bias),
//          FSM state encodings reused by iterative fp16 units, and an operand classifier.
// Ports:   none (package).
package fp16_div_pkg;

  localparam logic [15:0] FP16_QNAN     = 16'h7E00;
  localparam logic [15:0] FP16_ZERO     = 16'h0000;
  localparam logic [15:0] FP16_INF_POS  = 16'h7C00;
  localparam int          FP16_EXP_BIAS = 15;

  // State encodings for multi-cycle fp16 units (div today, sqrt later).
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_NORM = 3'd1;
  localparam logic [2:0] ST_DIV  = 3'd2;
  localparam logic [2:0] ST_PACK = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  typedef struct packed {
    logic zero;
    logic denorm;
    logic inf;
    logic nan;
  } fp16_class_t;

  // Classify the magnitude bits {exp[4:0], mant[9:0]}; a normal operand has all flags clear.
  function automatic fp16_class_t fp16_classify(input logic [14:0] mag);
    fp16_class_t c;
    c.zero   = (mag[14:10] == 5'd0)  && (mag[9:0] == 10'd0);
    c.denorm = (mag[14:10] == 5'd0)  && (mag[9:0] != 10'd0);
    c.inf    = (&mag[14:10])         && (mag[9:0] == 10'd0);
    c.nan    = (&mag[14:10])         && (mag[9:0] != 10'd0);
    return c;
  endfunction

endpackage

// File: rtl/fp16_lzc.sv
// rtl/fp16_lzc.sv - combinational 10-bit leading-zero counter
//
// Purpose: count leading zeros of a 10-bit mantissa field (all-zero input gives 10).
// Ports:   i_data  [9:0] field to scan, MSB first
//          o_count [3:0] number of leading zeros
import fp16_div_pkg::*;

module fp16_lzc (
  input  logic [9:0] i_data,
  output logic [3:0] o_count
);

  // Scan upwards so the highest set bit is the last one to write the count.
  always_comb begin
    o_count = 4'd10;
    for (int i = 0; i < 10; i++) begin
      if (i_data[i]) begin
        o_count = 4'(9 - i);
      end
    end
  end

endmodule

// File: rtl/fp16_div.sv
// rtl/fp16_div.sv - multi-cycle truncating IEEE 754 half-precision divider (restoring)
//
// Purpose: result = a / b, one operation in flight, valid/ready on both sides, no rounding.
// Ports:   clk, rst (sync, active-high)
//          in_valid/in_ready, a[15:0], b[15:0]       operand handshake
//          out_valid/out_ready, result[15:0]          result handshake (result registered)
//          div_by_zero                                finite nonzero a / zero b, qualified by out_valid
import fp16_div_pkg::*;

module fp16_div #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result,
  output logic        div_by_zero
);

  localparam int               N_ITER    = 12 / BITS_PER_CYCLE;
  localparam logic [3:0]       CNT_LAST  = 4'(N_ITER - 1);
  localparam logic signed [6:0] EXP_BIAS = 7'(FP16_EXP_BIAS);

  generate
    if (BITS_PER_CYCLE != 1 && BITS_PER_CYCLE != 2 && BITS_PER_CYCLE != 3 &&
        BITS_PER_CYCLE != 4 && BITS_PER_CYCLE != 6) begin : g_bad_bpc
      $error("fp16_div: BITS_PER_CYCLE must be 1, 2, 3, 4 or 6");
    end
  endgenerate

  logic [2:0]         r_state;
  logic [15:0]        r_a, r_b;
  logic               r_sign;
  logic signed [6:0]  r_exp;
  logic [11:0]        r_rem;
  logic [10:0]        r_div;
  logic [11:0]        r_q;
  logic [3:0]         r_cnt;
  logic               r_special;
  logic [15:0]        r_spec_res;
  logic               r_spec_dz;
  logic [15:0]        r_result;
  logic               r_dz;

  assign in_ready    = (r_state == ST_IDLE);
  assign out_valid   = (r_state == ST_DONE);
  assign result      = r_result;
  assign div_by_zero = r_dz;

  // ---------------- NORM: classify, specials, pre-normalize ----------------
  fp16_class_t       w_cls_a, w_cls_b;
  logic [3:0]        w_lz_a, w_lz_b;
  logic [10:0]       w_ma, w_mb;
  logic signed [6:0] w_ea, w_eb, w_e;
  logic              w_sign;
  logic              w_is_special;
  logic [15:0]       w_spec_res;
  logic              w_spec_dz;

  fp16_lzc u_lzc_a (.i_data(r_a[9:0]), .o_count(w_lz_a));
  fp16_lzc u_lzc_b (.i_data(r_b[9:0]), .o_count(w_lz_b));

  always_comb begin
    w_cls_a = fp16_classify(r_a[14:0]);
    w_cls_b = fp16_classify(r_b[14:0]);
    w_sign  = r_a[15] ^ r_b[15];

    // A denormal is shifted so its leading one lands on the hidden-bit position;
    // its effective exponent becomes -lz.
    w_ma = w_cls_a.denorm ? ({1'b0, r_a[9:0]} << (w_lz_a + 4'd1)) : {1'b1, r_a[9:0]};
    w_mb = w_cls_b.denorm ? ({1'b0, r_b[9:0]} << (w_lz_b + 4'd1)) : {1'b1, r_b[9:0]};
    w_ea = w_cls_a.denorm ? -$signed({3'b000, w_lz_a}) : $signed({2'b00, r_a[14:10]});
    w_eb = w_cls_b.denorm ? -$signed({3'b000, w_lz_b}) : $signed({2'b00, r_b[14:10]});
    w_e  = w_ea - w_eb + EXP_BIAS;

    w_is_special = 1'b1;
    w_spec_dz    = 1'b0;
    w_spec_res   = FP16_QNAN;
    if (w_cls_a.nan || w_cls_b.nan) begin
      w_spec_res = FP16_QNAN;
    end else if ((w_cls_a.zero && w_cls_b.zero) || (w_cls_a.inf && w_cls_b.inf)) begin
      w_spec_res = FP16_QNAN;
    end else if (w_cls_a.inf) begin
      w_spec_res = {w_sign, FP16_INF_POS[14:0]};
    end else if (w_cls_b.zero) begin
      // a is finite and nonzero here: the earlier branches took zero/inf/NaN a.
      w_spec_res = {w_sign, FP16_INF_POS[14:0]};
      w_spec_dz  = 1'b1;
    end else if (w_cls_a.zero || w_cls_b.inf) begin
      w_spec_res = {w_sign, 15'h0};
    end else begin
      w_is_special = 1'b0;
    end
  end

  // ---------------- DIV: BITS_PER_CYCLE restoring steps per cycle ----------------
  // rem stays below 2*divisor, so 12 bits never overflow.
  logic [11:0] w_rem_n;
  logic [11:0] w_q_n;

  always_comb begin
    w_rem_n = r_rem;
    w_q_n   = r_q;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      if (w_rem_n >= {1'b0, r_div}) begin
        w_rem_n = w_rem_n - {1'b0, r_div};
        w_q_n   = {w_q_n[10:0], 1'b1};
      end else begin
        w_q_n   = {w_q_n[10:0], 1'b0};
      end
      w_rem_n = w_rem_n << 1;
    end
  end

  // ---------------- PACK: normalize quotient, overflow / underflow ----------------
  logic [9:0]        w_pm;
  logic signed [6:0] w_pe;
  logic signed [6:0] w_sh;
  logic [9:0]        w_den;
  logic [15:0]       w_pack_res;

  always_comb begin
    // q lies in [2^10, 2^12): bit 11 set means the mantissa ratio was >= 1.
    w_pm  = r_q[11] ? r_q[10:1] : r_q[9:0];
    w_pe  = r_q[11] ? r_exp : (r_exp - 7'sd1);
    w_sh  = 7'sd1 - w_pe;
    w_den = 10'({1'b1, w_pm} >> w_sh[3:0]);
    if (w_pe >= 7'sd31) begin
      w_pack_res = {r_sign, FP16_INF_POS[14:0]};
    end else if (w_pe <= 7'sd0) begin
      w_pack_res = (w_sh >= 7'sd11) ? {r_sign, 15'h0} : {r_sign, 5'h00, w_den};
    end else begin
      w_pack_res = {r_sign, w_pe[4:0], w_pm};
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_result   <= FP16_ZERO;
      r_dz       <= 1'b0;
      r_cnt      <= 4'd0;
      r_special  <= 1'b0;
      r_spec_res <= FP16_ZERO;
      r_spec_dz  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_state <= ST_NORM;
          end
        end
        ST_NORM: begin
          r_sign     <= w_sign;
          r_special  <= w_is_special;
          r_spec_res <= w_spec_res;
          r_spec_dz  <= w_spec_dz;
          r_exp      <= w_e;
          r_rem      <= {1'b0, w_ma};
          r_div      <= w_mb;
          r_q        <= 12'd0;
          r_cnt      <= 4'd0;
          // Specials skip the divider but still pass PACK so the output
          // registers are loaded from a single place.
          r_state    <= w_is_special ? ST_PACK : ST_DIV;
        end
        ST_DIV: begin
          r_rem <= w_rem_n;
          r_q   <= w_q_n;
          if (r_cnt == CNT_LAST) begin
            r_state <= ST_PACK;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        ST_PACK: begin
          r_result <= r_special ? r_spec_res : w_pack_res;
          r_dz     <= r_special & r_spec_dz;
          r_state  <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_div.sv
// tb/tb_fp16_div.sv - directed self-checking bench for fp16_div
module tb_fp16_div;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, div_by_zero;
  logic [15:0] a, b, result;

  logic        in_valid3, in_ready3, out_valid3, out_ready3, div_by_zero3;
  logic [15:0] a3, b3, result3;

  int total = 0;
  int bad   = 0;

  fp16_div dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .div_by_zero(div_by_zero)
  );

  fp16_div #(.BITS_PER_CYCLE(3)) dut3 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid3), .in_ready(in_ready3), .a(a3), .b(b3),
    .out_valid(out_valid3), .out_ready(out_ready3),
    .result(result3), .div_by_zero(div_by_zero3)
  );

  // Issue one operation on dut; lat = edges from the accept edge to out_valid high.
  task automatic do_op(input logic [15:0] ia, input logic [15:0] ib,
                       output logic [15:0] res, output logic dz, output int lat);
    int w;
    a = ia; b = ib; in_valid = 1'b1; w = 0;
    while (!in_ready && w < 50) begin @(posedge clk); #1; w++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    res = result; dz = div_by_zero;
    if (out_ready) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    total++; if (in_ready !== 1'b1)     begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    total++; if (out_valid !== 1'b0)    begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (result !== 16'h0000)   begin bad++; $display("FAIL reset_result: got %h want 0000", result); end
    total++; if (div_by_zero !== 1'b0)  begin bad++; $display("FAIL reset_dz: got %b want 0", div_by_zero); end
  endtask

  task automatic test_vectors();
    // 4/2, 1/3, specials, range limits
    logic [15:0] va[9] = '{16'h4400, 16'h3C00, 16'h3C00, 16'h0000, 16'hFC00, 16'h3C00, 16'h0001, 16'h0001, 16'h7BFF};
    logic [15:0] vb[9] = '{16'h4000, 16'h4200, 16'h0000, 16'h0000, 16'h4000, 16'h7C00, 16'h3800, 16'h4000, 16'h3800};
    logic [15:0] vr[9] = '{16'h4000, 16'h3555, 16'h7C00, 16'h7E00, 16'hFC00, 16'h0000, 16'h0002, 16'h0000, 16'h7C00};
    logic        vd[9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    int          vl[9] = '{14, 14, 2, 2, 2, 2, 14, 14, 14};
    logic [15:0] res;
    logic        dz;
    int          lat;
    for (int i = 0; i < 9; i++) begin
      do_op(va[i], vb[i], res, dz, lat);
      total++; if (res !== vr[i]) begin bad++; $display("FAIL vec%0d_result %h/%h: got %h want %h", i, va[i], vb[i], res, vr[i]); end
      total++; if (dz !== vd[i])  begin bad++; $display("FAIL vec%0d_dz: got %b want %b", i, dz, vd[i]); end
      total++; if (lat != vl[i])  begin bad++; $display("FAIL vec%0d_latency: got %0d want %0d", i, lat, vl[i]); end
    end
  endtask

  task automatic test_bpc3();
    int w;
    int lat;
    a3 = 16'h3C00; b3 = 16'h4200; in_valid3 = 1'b1; w = 0;
    while (!in_ready3 && w < 50) begin @(posedge clk); #1; w++; end
    @(posedge clk); #1;
    in_valid3 = 1'b0;
    lat = 0;
    while (!out_valid3 && lat < 100) begin @(posedge clk); #1; lat++; end
    total++; if (result3 !== 16'h3555) begin bad++; $display("FAIL bpc3_result: got %h want 3555", result3); end
    total++; if (div_by_zero3 !== 1'b0) begin bad++; $display("FAIL bpc3_dz: got %b want 0", div_by_zero3); end
    total++; if (lat != 6) begin bad++; $display("FAIL bpc3_latency: got %0d want 6", lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [15:0] res;
    logic        dz;
    int          lat;
    out_ready = 1'b0;
    do_op(16'h4400, 16'h4000, res, dz, lat);
    total++; if (res !== 16'h4000) begin bad++; $display("FAIL bp_first_result: got %h want 4000", res); end
    // pending operation while the result waits
    a = 16'h3C00; b = 16'h4200; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b1)  begin bad++; $display("FAIL bp_hold_valid c%0d: got %b want 1", c, out_valid); end
      total++; if (result !== 16'h4000) begin bad++; $display("FAIL bp_hold_result c%0d: got %h want 4000", c, result); end
      total++; if (in_ready !== 1'b0)   begin bad++; $display("FAIL bp_hold_in_ready c%0d: got %b want 0", c, in_ready); end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL bp_release_in_ready: got %b want 1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_out_valid: got %b want 0", out_valid); end
    do_op(16'h3C00, 16'h4200, res, dz, lat);
    total++; if (res !== 16'h3555) begin bad++; $display("FAIL bp_second_result: got %h want 3555", res); end
    total++; if (lat != 14)        begin bad++; $display("FAIL bp_second_latency: got %0d want 14", lat); end
  endtask

  task automatic test_reset_mid_div();
    logic [15:0] res;
    logic        dz;
    int          lat;
    int          seen;
    a = 16'h3C00; b = 16'h4200; in_valid = 1'b1;
    @(posedge clk); #1;          // accept edge (dut idle)
    in_valid = 1'b0;
    repeat (6) @(posedge clk);   // NORM, then 5 DIV iterations
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++; if (out_valid !== 1'b0)  begin bad++; $display("FAIL rst_mid_out_valid: got %b want 0", out_valid); end
    total++; if (in_ready !== 1'b1)   begin bad++; $display("FAIL rst_mid_in_ready: got %b want 1", in_ready); end
    total++; if (result !== 16'h0000) begin bad++; $display("FAIL rst_mid_result: got %h want 0000", result); end
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL rst_mid_stale_output: got %0d valid cycles want 0", seen); end
    do_op(16'h4400, 16'h4000, res, dz, lat);
    total++; if (res !== 16'h4000) begin bad++; $display("FAIL rst_mid_new_result: got %h want 4000", res); end
    total++; if (lat != 14)        begin bad++; $display("FAIL rst_mid_new_latency: got %0d want 14", lat); end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1; a = 16'h0; b = 16'h0;
    in_valid3 = 1'b0; out_ready3 = 1'b1; a3 = 16'h0; b3 = 16'h0;
    test_reset();
    test_vectors();
    test_bpc3();
    test_backpressure();
    test_reset_mid_div();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
